// File: rtl/z80_bus_trace.sv
// Z80 bus-activity capture: decodes strobe edges into fixed-format records
// and buffers them in a first-word-fall-through FIFO with a drop counter.
module z80_bus_trace #(
   parameter int DEPTH = 16
) (
   input  logic                     eclk,
   input  logic                     _ereset,
   input  logic                     clk,
   input  logic [15:0]              ab,
   input  logic [7:0]               db_i,
   input  logic [7:0]               db_o,
   input  logic                     _rd,
   input  logic                     _wr,
   input  logic                     _mreq,
   input  logic                     _iorq,
   input  logic                     _m1,
   input  logic                     _reset,
   input  logic                     _halt,
   input  logic                     enable,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [2:0]               out_type,
   output logic [15:0]              out_addr,
   output logic [7:0]               out_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               drop_cnt,
   output logic                     halted
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   localparam logic [2:0] T_FETCH = 3'd0;
   localparam logic [2:0] T_MRD   = 3'd1;
   localparam logic [2:0] T_IORD  = 3'd2;
   localparam logic [2:0] T_MWR   = 3'd3;
   localparam logic [2:0] T_IOWR  = 3'd4;
   localparam logic [2:0] T_RSTA  = 3'd5;
   localparam logic [2:0] T_RSTR  = 3'd6;
   localparam logic [2:0] T_HALT  = 3'd7;

   logic          clk_q;
   logic          rd_l_q, wr_l_q, reset_l_q, halt_l_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q, level_d;
   logic [7:0]    drop_q, drop_d;
   logic          halted_q;
   logic [26:0]   mem_q [DEPTH];

   logic          z_edge;
   logic          halt_ev, rsta_ev, rstr_ev, rd_ev, wr_ev;
   logic [2:0]    n_ev, lost;
   logic [2:0]    rec_type;
   logic [7:0]    rec_data;
   logic          push_req, accept, pop;
   logic [8:0]    drop_sum;
   logic [26:0]   head;

   // Edge/event decode; everything is gated to the single eclk cycle of a Z80 rising edge.
   always_comb begin
      z_edge  = clk & ~clk_q;
      halt_ev = z_edge & enable & halt_l_q & ~_halt;
      rsta_ev = z_edge & enable & reset_l_q & ~_reset;
      rstr_ev = z_edge & enable & ~reset_l_q & _reset;
      rd_ev   = z_edge & enable & rd_l_q & ~_rd & (~_mreq | ~_iorq);
      wr_ev   = z_edge & enable & wr_l_q & ~_wr & (~_mreq | ~_iorq);

      rec_type = T_FETCH;
      rec_data = 8'h00;
      if (halt_ev) begin
         rec_type = T_HALT;
      end else if (rsta_ev) begin
         rec_type = T_RSTA;
      end else if (rstr_ev) begin
         rec_type = T_RSTR;
      end else if (rd_ev) begin
         rec_data = db_i;
         if (!_mreq) rec_type = _m1 ? T_MRD : T_FETCH;
         else        rec_type = T_IORD;
      end else if (wr_ev) begin
         rec_data = db_o;
         rec_type = !_mreq ? T_MWR : T_IOWR;
      end

      n_ev = {2'b00, halt_ev} + {2'b00, rsta_ev | rstr_ev} + {2'b00, rd_ev} + {2'b00, wr_ev};
   end

   // FIFO control and drop accounting.
   always_comb begin
      pop      = out_valid & out_ready;
      push_req = (n_ev != 3'd0);
      accept   = push_req & ((level_q != FULL_LVL) | pop);
      lost     = n_ev - {2'b00, accept};

      drop_sum = {1'b0, drop_q} + {6'b000000, lost};
      drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];

      level_d = level_q;
      case ({accept, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge eclk or negedge _ereset) begin
      if (!_ereset) begin
         clk_q     <= 1'b0;
         rd_l_q    <= 1'b1;
         wr_l_q    <= 1'b1;
         reset_l_q <= 1'b1;
         halt_l_q  <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         drop_q    <= 8'h00;
         halted_q  <= 1'b0;
      end else begin
         clk_q <= clk;
         if (z_edge) begin
            rd_l_q    <= _rd;
            wr_l_q    <= _wr;
            reset_l_q <= _reset;
            halt_l_q  <= _halt;
         end
         if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
         drop_q  <= drop_d;
         if (accept && (rec_type == T_HALT)) halted_q <= 1'b1;
      end
   end

   // Storage carries no reset; out_* are masked while empty.
   always_ff @(posedge eclk) begin
      if (accept) mem_q[wr_ptr_q] <= {rec_type, ab, rec_data};
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_valid = (level_q != '0);
   assign out_type  = out_valid ? head[26:24] : 3'd0;
   assign out_addr  = out_valid ? head[23:8]  : 16'h0000;
   assign out_data  = out_valid ? head[7:0]   : 8'h00;
   assign level     = level_q;
   assign drop_cnt  = drop_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_z80_bus_trace.sv
// Directed bench for z80_bus_trace with hand-computed expected records.
module tb_z80_bus_trace;

   localparam int DEPTH = 16;

   logic        eclk = 1'b0;
   logic        _ereset = 1'b0;
   logic        clk = 1'b0;
   logic [15:0] ab = 16'h0000;
   logic [7:0]  db_i = 8'h00, db_o = 8'h00;
   logic        _rd = 1'b1, _wr = 1'b1, _mreq = 1'b1, _iorq = 1'b1;
   logic        _m1 = 1'b1, _reset = 1'b1, _halt = 1'b1;
   logic        enable = 1'b1;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_type;
   logic [15:0] out_addr;
   logic [7:0]  out_data;
   logic [4:0]  level;
   logic [7:0]  drop_cnt;
   logic        halted;

   int n_assert = 0;
   int n_fail   = 0;

   z80_bus_trace #(.DEPTH(DEPTH)) dut (
      .eclk(eclk), ._ereset(_ereset), .clk(clk), .ab(ab), .db_i(db_i), .db_o(db_o),
      ._rd(_rd), ._wr(_wr), ._mreq(_mreq), ._iorq(_iorq), ._m1(_m1),
      ._reset(_reset), ._halt(_halt), .enable(enable),
      .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
      .out_addr(out_addr), .out_data(out_data), .level(level),
      .drop_cnt(drop_cnt), .halted(halted)
   );

   always #5 eclk = ~eclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [2:0] t, input logic [15:0] a,
                           input logic [7:0] d);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".type"},  {29'd0, out_type}, {29'd0, t});
      chk({tag, ".addr"},  {16'd0, out_addr}, {16'd0, a});
      chk({tag, ".data"},  {24'd0, out_data}, {24'd0, d});
   endtask

   // One Z80 clock: strobes applied with clk rising, then clk low for one eclk.
   task automatic zstep(input logic rd, wr, mreq, iorq, m1, rs, hl,
                        input logic [15:0] a, input logic [7:0] di, dout);
      _rd = rd; _wr = wr; _mreq = mreq; _iorq = iorq; _m1 = m1;
      _reset = rs; _halt = hl; ab = a; db_i = di; db_o = dout;
      clk = 1'b1;
      @(negedge eclk);
      clk = 1'b0;
      @(negedge eclk);
   endtask

   task automatic idle(input logic rs, hl);
      zstep(1, 1, 1, 1, 1, rs, hl, 16'h0000, 8'h00, 8'h00);
   endtask

   task automatic pop1();
      out_ready = 1'b1;
      @(negedge eclk);
      out_ready = 1'b0;
   endtask

   initial begin
      @(negedge eclk);
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.type",  {29'd0, out_type}, 32'd0);
      chk("rst.addr",  {16'd0, out_addr}, 32'd0);
      chk("rst.data",  {24'd0, out_data}, 32'd0);
      chk("rst.level", {27'd0, level}, 32'd0);
      chk("rst.drop",  {24'd0, drop_cnt}, 32'd0);
      chk("rst.halted", {31'd0, halted}, 32'd0);
      _ereset = 1'b1;
      @(negedge eclk);
      @(negedge eclk);

      // Fetch with latency check
      _rd = 0; _mreq = 0; _m1 = 0; ab = 16'h0000; db_i = 8'h3e; clk = 1'b1;
      chk("fetch.pre_valid", {31'd0, out_valid}, 32'd0);
      @(negedge eclk);
      chk_head("fetch", 3'd0, 16'h0000, 8'h3e);
      chk("fetch.level", {27'd0, level}, 32'd1);
      clk = 1'b0;
      @(negedge eclk);
      idle(1, 1);
      pop1();
      chk("fetch.drain", {27'd0, level}, 32'd0);

      // Memory write then IO read
      zstep(1, 0, 0, 1, 1, 1, 1, 16'h1ffe, 8'h00, 8'hf5);
      idle(1, 1);
      zstep(0, 1, 1, 0, 1, 1, 1, 16'h0010, 8'h5a, 8'h00);
      idle(1, 1);
      chk("wrrd.level", {27'd0, level}, 32'd2);
      chk_head("memwr", 3'd3, 16'h1ffe, 8'hf5);
      pop1();
      chk_head("iord", 3'd2, 16'h0010, 8'h5a);
      pop1();
      chk("wrrd.drain", {27'd0, level}, 32'd0);

      // Reset held low for 3 Z80 clocks, release coincides with a read fall
      zstep(1, 1, 1, 1, 1, 0, 1, 16'h1234, 8'h00, 8'h00);
      zstep(1, 1, 1, 1, 1, 0, 1, 16'h1235, 8'h00, 8'h00);
      zstep(1, 1, 1, 1, 1, 0, 1, 16'h1236, 8'h00, 8'h00);
      zstep(0, 1, 0, 1, 1, 1, 1, 16'h2000, 8'h77, 8'h00);
      idle(1, 1);
      chk("rst_seq.level", {27'd0, level}, 32'd2);
      chk("rst_seq.drop",  {24'd0, drop_cnt}, 32'd1);
      chk_head("rst_asserted", 3'd5, 16'h1234, 8'h00);
      pop1();
      chk_head("rst_released", 3'd6, 16'h2000, 8'h00);
      pop1();

      // Overfill with consumer stalled
      for (int i = 0; i < DEPTH + 3; i++) begin
         zstep(0, 1, 0, 1, 0, 1, 1, 16'(i), 8'(8'h40 + i), 8'h00);
         idle(1, 1);
      end
      chk("full.level", {27'd0, level}, 32'd16);
      chk("full.drop",  {24'd0, drop_cnt}, 32'd4);
      chk_head("full.head", 3'd0, 16'h0000, 8'h40);

      // Push and pop in the same cycle while full
      _rd = 0; _mreq = 0; _m1 = 1; ab = 16'h0100; db_i = 8'h99; clk = 1'b1; out_ready = 1'b1;
      @(negedge eclk);
      out_ready = 1'b0; clk = 1'b0;
      chk("fullpp.level", {27'd0, level}, 32'd16);
      chk("fullpp.drop",  {24'd0, drop_cnt}, 32'd4);
      @(negedge eclk);
      idle(1, 1);
      out_ready = 1'b1;
      for (int i = 1; i < DEPTH; i++) begin
         chk("drain.level", {27'd0, level}, 32'(DEPTH + 1 - i));
         chk_head("drain", 3'd0, 16'(i), 8'(8'h40 + i));
         @(negedge eclk);
      end
      chk_head("drain.last", 3'd1, 16'h0100, 8'h99);
      @(negedge eclk);
      out_ready = 1'b0;
      chk("drain.level0", {27'd0, level}, 32'd0);
      chk("drain.valid0", {31'd0, out_valid}, 32'd0);

      // Halt record, then held low
      zstep(1, 1, 1, 1, 1, 1, 0, 16'h0777, 8'h00, 8'h00);
      chk_head("halt", 3'd7, 16'h0777, 8'h00);
      chk("halt.halted", {31'd0, halted}, 32'd1);
      zstep(1, 1, 1, 1, 1, 1, 0, 16'h0778, 8'h00, 8'h00);
      zstep(1, 1, 1, 1, 1, 1, 0, 16'h0779, 8'h00, 8'h00);
      chk("halt.once", {27'd0, level}, 32'd1);
      pop1();

      // Capture disabled: nothing recorded or counted
      enable = 1'b0;
      zstep(0, 1, 0, 1, 0, 1, 0, 16'h0abc, 8'h11, 8'h00);
      idle(1, 0);
      enable = 1'b1;
      chk("dis.level", {27'd0, level}, 32'd0);
      chk("dis.drop",  {24'd0, drop_cnt}, 32'd4);

      // Drop counter saturation
      for (int i = 0; i < 300; i++) begin
         zstep(0, 1, 0, 1, 0, 1, 0, 16'(16'h3000 + i), 8'h22, 8'h00);
         idle(1, 0);
      end
      chk("sat.drop",  {24'd0, drop_cnt}, 32'd255);
      chk("sat.level", {27'd0, level}, 32'd16);
      chk("sat.halted", {31'd0, halted}, 32'd1);

      // Asynchronous reset mid-stream
      #2;
      _ereset = 1'b0;
      _halt = 1'b1;
      #1;
      chk("arst.valid", {31'd0, out_valid}, 32'd0);
      chk("arst.type",  {29'd0, out_type}, 32'd0);
      chk("arst.addr",  {16'd0, out_addr}, 32'd0);
      chk("arst.data",  {24'd0, out_data}, 32'd0);
      chk("arst.level", {27'd0, level}, 32'd0);
      chk("arst.drop",  {24'd0, drop_cnt}, 32'd0);
      chk("arst.halted", {31'd0, halted}, 32'd0);
      @(negedge eclk);
      _ereset = 1'b1;
      @(negedge eclk);

      // Post-reset IO write
      zstep(1, 0, 1, 0, 1, 1, 1, 16'h00fe, 8'h00, 8'hc3);
      idle(1, 1);
      chk_head("post.iowr", 3'd4, 16'h00fe, 8'hc3);
      chk("post.level", {27'd0, level}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
